feistel_cipher_core: RTL and testbench

Parametrised iterative Feistel block cipher with encrypt and decrypt modes. It replaces the fixed 128-bit single-shot encryptor and adds valid/ready handshakes on input and output. One round executes per clock. Key width equals block width.

---
 rtl/feistel_cipher_core.sv | 111 +++++++++++
 tb/tb_feistel_cipher_core.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/feistel_cipher_core.sv
// Iterative Feistel block cipher with encrypt/decrypt modes and valid/ready handshakes.
// A single combinational round is reused, one round per clock.
module feistel_cipher_core #(
    parameter int BLOCK_W = 128,
    parameter int ROUNDS  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic [BLOCK_W-1:0] key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy
);
    localparam int H  = BLOCK_W / 2;
    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    // For H >= 31 every legal int value of ROUNDS is below 2^H.
    generate
        if ((BLOCK_W % 2) != 0 || BLOCK_W < 8) begin : g_bad_width
            $error("feistel_cipher_core: BLOCK_W must be even and >= 8");
        end
        if (ROUNDS < 1 || (H < 31 && ROUNDS > (1 << ((H < 31) ? H : 0)))) begin : g_bad_rounds
            $error("feistel_cipher_core: ROUNDS must be in 1 .. 2^(BLOCK_W/2)");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [H-1:0]       l;
    logic [H-1:0]       r;
    logic [BLOCK_W-1:0] key_q;
    logic               mode_q;
    logic [CW-1:0]      cnt;

    logic [CW-1:0]      last;
    logic [CW-1:0]      idx;
    logic [H-1:0]       rk;
    logic [H-1:0]       sum;
    logic [H-1:0]       f;

    assign last = CW'(ROUNDS - 1);

    // Decrypt walks the round keys backwards; the round itself is identical.
    always_comb begin
        idx = mode_q ? (last - cnt) : cnt;
        rk  = (idx[0] ? key_q[BLOCK_W-1:H] : key_q[H-1:0]) ^ H'(idx);
        sum = r + rk;
        f   = {sum[H-2:0], sum[H-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)    state_nxt = RUN;
            RUN:     if (cnt == last) state_nxt = DONE;
            DONE:    if (out_ready)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l      <= '0;
            r      <= '0;
            key_q  <= '0;
            mode_q <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        l      <= in_data[BLOCK_W-1:H];
                        r      <= in_data[H-1:0];
                        key_q  <= key;
                        mode_q <= mode;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    l   <= r;
                    r   <= l ^ f;
                    cnt <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // The final half swap is folded into the output ordering.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = (state == DONE) ? {r, l} : '0;

endmodule

// File: tb/tb_feistel_cipher_core.sv
// Self-checking bench: an 8-bit/2-round core for known vectors and
// a default 128/16 core for round-trip checks, sharing a scoreboard queue.
module tb_feistel_cipher_core;
    logic         clk;
    logic         rst;
    logic         sel;
    logic         in_valid;
    logic         mode;
    logic [127:0] in_data;
    logic [127:0] key;
    logic         out_ready;

    logic         s_in_ready, s_out_valid, s_busy;
    logic [7:0]   s_out_data;
    logic         b_in_ready, b_out_valid, b_busy;
    logic [127:0] b_out_data;

    logic         cur_in_ready, cur_out_valid, cur_busy;
    logic [127:0] cur_out_data;

    int           checks;
    int           errors;
    logic [127:0] exp_q[$];
    logic [127:0] res;
    logic [127:0] enc;

    feistel_cipher_core #(.BLOCK_W(8), .ROUNDS(2)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & ~sel), .in_ready(s_in_ready),
        .mode(mode), .in_data(in_data[7:0]), .key(key[7:0]),
        .out_valid(s_out_valid), .out_ready(out_ready & ~sel),
        .out_data(s_out_data), .busy(s_busy)
    );

    feistel_cipher_core #(.BLOCK_W(128), .ROUNDS(16)) dut128 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & sel), .in_ready(b_in_ready),
        .mode(mode), .in_data(in_data), .key(key),
        .out_valid(b_out_valid), .out_ready(out_ready & sel),
        .out_data(b_out_data), .busy(b_busy)
    );

    assign cur_in_ready  = sel ? b_in_ready  : s_in_ready;
    assign cur_out_valid = sel ? b_out_valid : s_out_valid;
    assign cur_busy      = sel ? b_busy      : s_busy;
    assign cur_out_data  = sel ? b_out_data  : {120'd0, s_out_data};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cipher written straight from the algorithm description.
    function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k,
                                           input logic m, input int w, input int rounds);
        int          h;
        logic [63:0] mask, l, r, kh, kl, rk, s, f, t, idx;
        h    = w / 2;
        mask = (h >= 64) ? '1 : ((64'd1 << h) - 64'd1);
        l    = 64'(d >> h) & mask;
        r    = d[63:0] & mask;
        kh   = 64'(k >> h) & mask;
        kl   = k[63:0] & mask;
        for (int i = 0; i < rounds; i++) begin
            idx = 64'(m ? (rounds - 1 - i) : i);
            rk  = ((idx[0]) ? kh : kl) ^ idx;
            s   = (r + rk) & mask;
            f   = ((s << 1) | (s >> (h - 1))) & mask;
            t   = l ^ f;
            l   = r;
            r   = t;
        end
        return ({64'd0, r} << h) | {64'd0, l};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [127:0] d, input logic [127:0] k,
                                 input logic [127:0] exp);
        @(negedge clk);
        mode     = m;
        in_data  = d;
        key      = k;
        in_valid = 1'b1;
        checkOutput("in_ready_idle", 128'(cur_in_ready), 128'd1);
        @(posedge clk);
        #1;
        exp_q.push_back(exp);
        // Scramble inputs after accept to prove key/mode/data were latched.
        in_valid = 1'b0;
        in_data  = ~d;
        key      = ~k;
        mode     = ~m;
    endtask

    task automatic waitResult(input int rounds, input int hold, output logic [127:0] got);
        int           edges;
        logic [127:0] exp;
        edges = 0;
        checkOutput("run_in_ready", 128'(cur_in_ready), 128'd0);
        checkOutput("run_busy", 128'(cur_busy), 128'd1);
        checkOutput("run_out_data", cur_out_data, 128'd0);
        while (cur_out_valid !== 1'b1 && edges < rounds + 8) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("latency", 128'(edges), 128'(rounds));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        got = cur_out_data;
        checkOutput("out_data", cur_out_data, exp);
        checkOutput("done_in_ready", 128'(cur_in_ready), 128'd0);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            key      = {$urandom, $urandom, $urandom, $urandom};
            mode     = c[0];
            @(posedge clk);
            #1;
            checkOutput("hold_valid", 128'(cur_out_valid), 128'd1);
            checkOutput("hold_data", cur_out_data, exp);
            checkOutput("hold_in_ready", 128'(cur_in_ready), 128'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("ret_in_ready", 128'(cur_in_ready), 128'd1);
        checkOutput("ret_out_valid", 128'(cur_out_valid), 128'd0);
        checkOutput("ret_out_data", cur_out_data, 128'd0);
        checkOutput("ret_busy", 128'(cur_busy), 128'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        sel       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        mode      = 1'b0;
        in_data   = 128'h3C;
        key       = 128'hA5;
        out_ready = 1'b0;
        $display("[TB] start");

        // Reset held with a pending request must not accept it.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 128'(s_in_ready), 128'd1);
        checkOutput("rst_out_valid", 128'(s_out_valid), 128'd0);
        checkOutput("rst_out_data", 128'(s_out_data), 128'd0);
        checkOutput("rst_busy", 128'(s_busy), 128'd0);
        checkOutput("rst_busy_big", 128'(b_busy), 128'd0);
        checkOutput("rst_out_data_big", b_out_data, 128'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        $display("[TB] known vector encrypt/decrypt");
        applyStimulus(1'b0, 128'h3C, 128'hA5, 128'h51);
        waitResult(2, 0, res);
        applyStimulus(1'b1, 128'h51, 128'hA5, 128'h3C);
        waitResult(2, 0, res);

        $display("[TB] backpressure");
        applyStimulus(1'b0, 128'h3C, 128'hA5, 128'h51);
        waitResult(2, 5, res);

        $display("[TB] default configuration round trips");
        sel = 1'b1;
        applyStimulus(1'b0, 128'd1407, 128'd25, model(128'd1407, 128'd25, 1'b0, 128, 16));
        waitResult(16, 0, enc);
        checks++;
        assert (enc !== 128'd1407) else begin
            errors++;
            $error("FAIL enc_differs observed=%h expected=not %h", enc, 128'd1407);
        end
        applyStimulus(1'b1, enc, 128'd25, 128'd1407);
        waitResult(16, 0, res);
        applyStimulus(1'b0, 128'd285, 128'd1293, model(128'd285, 128'd1293, 1'b0, 128, 16));
        waitResult(16, 0, enc);
        applyStimulus(1'b1, enc, 128'd1293, 128'd285);
        waitResult(16, 0, res);

        $display("[TB] reset mid-operation");
        sel = 1'b0;
        applyStimulus(1'b0, 128'h3C, 128'hA5, 128'h51);
        @(posedge clk);
        #1;
        checkOutput("mid_busy", 128'(s_busy), 128'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_in_ready", 128'(s_in_ready), 128'd1);
        checkOutput("mid_rst_busy", 128'(s_busy), 128'd0);
        checkOutput("mid_rst_out_data", 128'(s_out_data), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int e = 0; e < 4; e++) begin
            @(posedge clk);
            #1;
            checkOutput("mid_no_valid", 128'(s_out_valid), 128'd0);
        end
        applyStimulus(1'b0, 128'h3C, 128'hA5, 128'h51);
        waitResult(2, 0, res);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
